bip_datapath: RTL and testbench

BIP_DATAPATH -- requirements
Module: bip_datapath

---
 rtl/bip_datapath.sv | 113 +++++++++++
 tb/tb_bip_datapath.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/bip_datapath.sv
// -----------------------------------------------------------------------------
// bip_datapath
//   Datapath of a small accumulator-based processor (BIP). It contains the
//   accumulator, an add/sub ALU with a sticky signed-overflow flag, and a data
//   RAM with a combinational read port. A second combinational read port
//   serves debug access.
//
// Ports
//   i_clock       rising-edge clock
//   i_reset       asynchronous active-high reset (clears acc and overflow)
//   i_operand     instruction operand: RAM address or 11-bit immediate
//   i_sel_a       accumulator source: 00 mem, 01 imm, 10 alu, 11 hold
//   i_sel_b       ALU B operand: 0 mem, 1 imm
//   i_enb_acc     accumulator load enable
//   i_operation   ALU operation: 0 add, 1 sub
//   i_wr_enb_ram  store accumulator into RAM[i_operand]
//   i_rd_enb_ram  read RAM[i_operand] onto the memory bus (zero otherwise)
//   i_dbg_addr    debug read address
//   o_acc         accumulator value
//   o_overflow    sticky signed-overflow flag
//   o_dbg_data    RAM[i_dbg_addr], combinational
// -----------------------------------------------------------------------------
module bip_datapath #(
  parameter int NB_DATA       = 16,
  parameter int NB_ADDR       = 11,
  parameter int NB_SELECTOR_A = 2
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic [NB_ADDR-1:0]       i_operand,
  input  logic [NB_SELECTOR_A-1:0] i_sel_a,
  input  logic                     i_sel_b,
  input  logic                     i_enb_acc,
  input  logic                     i_operation,
  input  logic                     i_wr_enb_ram,
  input  logic                     i_rd_enb_ram,
  input  logic [NB_ADDR-1:0]       i_dbg_addr,
  output logic [NB_DATA-1:0]       o_acc,
  output logic                     o_overflow,
  output logic [NB_DATA-1:0]       o_dbg_data
);

  localparam int RAM_DEPTH = 2 ** NB_ADDR;

  localparam logic [NB_SELECTOR_A-1:0] SEL_MEM = NB_SELECTOR_A'(0);
  localparam logic [NB_SELECTOR_A-1:0] SEL_IMM = NB_SELECTOR_A'(1);
  localparam logic [NB_SELECTOR_A-1:0] SEL_ALU = NB_SELECTOR_A'(2);

  // Contents are all-zero at configuration; reset never touches the RAM.
  logic [NB_DATA-1:0] r_ram [RAM_DEPTH] = '{default: '0};

  logic [NB_DATA-1:0] r_acc;
  logic               r_overflow;

  logic [NB_DATA-1:0] w_imm;
  logic [NB_DATA-1:0] w_mem_data;
  logic [NB_DATA-1:0] w_b;
  logic [NB_DATA-1:0] w_alu;
  logic               w_alu_overflow;
  logic [NB_DATA-1:0] w_acc_next;

  assign w_imm      = {{(NB_DATA - NB_ADDR){i_operand[NB_ADDR-1]}}, i_operand};
  assign w_mem_data = i_rd_enb_ram ? r_ram[i_operand] : '0;
  assign w_b        = i_sel_b ? w_imm : w_mem_data;
  assign w_alu      = i_operation ? (r_acc - w_b) : (r_acc + w_b);

  // Signed overflow: for add the operands share a sign, for sub they differ,
  // and in both cases the result sign differs from the accumulator sign.
  always_comb begin
    w_alu_overflow = 1'b0;
    if (i_operation) begin
      w_alu_overflow = (r_acc[NB_DATA-1] != w_b[NB_DATA-1]) &&
                       (w_alu[NB_DATA-1] != r_acc[NB_DATA-1]);
    end else begin
      w_alu_overflow = (r_acc[NB_DATA-1] == w_b[NB_DATA-1]) &&
                       (w_alu[NB_DATA-1] != r_acc[NB_DATA-1]);
    end
  end

  always_comb begin
    w_acc_next = r_acc;
    case (i_sel_a)
      SEL_MEM: w_acc_next = w_mem_data;
      SEL_IMM: w_acc_next = w_imm;
      SEL_ALU: w_acc_next = w_alu;
      default: w_acc_next = r_acc;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_acc      <= '0;
      r_overflow <= 1'b0;
    end else if (i_enb_acc) begin
      r_acc <= w_acc_next;
      if ((i_sel_a == SEL_ALU) && w_alu_overflow) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Stores the pre-edge accumulator; a same-cycle read sees the old word.
  always_ff @(posedge i_clock) begin
    if (i_wr_enb_ram && !i_reset) begin
      r_ram[i_operand] <= r_acc;
    end
  end

  assign o_acc      = r_acc;
  assign o_overflow = r_overflow;
  assign o_dbg_data = r_ram[i_dbg_addr];

endmodule

// File: tb/tb_bip_datapath.sv
module tb_bip_datapath;

  logic        clk = 1'b0;
  logic        i_reset;
  logic [10:0] i_operand;
  logic [1:0]  i_sel_a;
  logic        i_sel_b;
  logic        i_enb_acc;
  logic        i_operation;
  logic        i_wr_enb_ram;
  logic        i_rd_enb_ram;
  logic [10:0] i_dbg_addr;
  logic [15:0] o_acc;
  logic        o_overflow;
  logic [15:0] o_dbg_data;

  always #5 clk = ~clk;

  bip_datapath #(.NB_DATA(16), .NB_ADDR(11), .NB_SELECTOR_A(2)) dut (
    .i_clock      (clk),
    .i_reset      (i_reset),
    .i_operand    (i_operand),
    .i_sel_a      (i_sel_a),
    .i_sel_b      (i_sel_b),
    .i_enb_acc    (i_enb_acc),
    .i_operation  (i_operation),
    .i_wr_enb_ram (i_wr_enb_ram),
    .i_rd_enb_ram (i_rd_enb_ram),
    .i_dbg_addr   (i_dbg_addr),
    .o_acc        (o_acc),
    .o_overflow   (o_overflow),
    .o_dbg_data   (o_dbg_data)
  );

  typedef struct {
    int    acc;
    int    ovf;
    int    dbg;
    string name;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: plain integers, accumulator held as 0..65535.
  int m_acc = 0;
  int m_ovf = 0;
  int m_ram [2048];

  function automatic int sx(input int v, input int bits);
    return (v >= (1 << (bits - 1))) ? v - (1 << bits) : v;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Drive one cycle of inputs, advance the model and queue the expected
  // post-edge state.
  task automatic drive(input int rst, input int sel_a, input int sel_b, input int op,
                       input int enb, input int wr, input int rd, input int operand,
                       input int dbg, input string name);
    int imm, mem, b, res, old;
    exp_t e;
    @(negedge clk);
    i_reset      = rst[0];
    i_sel_a      = sel_a[1:0];
    i_sel_b      = sel_b[0];
    i_operation  = op[0];
    i_enb_acc    = enb[0];
    i_wr_enb_ram = wr[0];
    i_rd_enb_ram = rd[0];
    i_operand    = operand[10:0];
    i_dbg_addr   = dbg[10:0];
    if (rst != 0) begin
      m_acc = 0;
      m_ovf = 0;
    end else begin
      imm = sx(operand, 11);
      mem = (rd != 0) ? m_ram[operand] : 0;
      b   = (sel_b != 0) ? imm : sx(mem, 16);
      res = (op != 0) ? sx(m_acc, 16) - b : sx(m_acc, 16) + b;
      old = m_acc;
      if (wr != 0) m_ram[operand] = old;
      if (enb != 0) begin
        case (sel_a)
          0: m_acc = mem;
          1: m_acc = imm & 16'hFFFF;
          2: begin
            m_acc = res & 16'hFFFF;
            if (res > 32767 || res < -32768) m_ovf = 1;
          end
          default: ;
        endcase
      end
    end
    e.acc  = m_acc;
    e.ovf  = m_ovf;
    e.dbg  = m_ram[dbg];
    e.name = name;
    q.push_back(e);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic imm_op(input int sel_a, input int op, input int v);
    drive(0, sel_a, 1, op, 1, 0, 0, v, 0, "imm_op");
    settle();
  endtask

  // Monitor: pops one expectation per edge for which the driver issued one.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk({e.name, "_acc"}, int'(o_acc), e.acc);
      chk({e.name, "_ovf"}, int'(o_overflow), e.ovf);
      chk({e.name, "_dbg"}, int'(o_dbg_data), e.dbg);
    end
  end

  initial begin
    i_reset = 0; i_operand = 0; i_sel_a = 0; i_sel_b = 0; i_enb_acc = 0;
    i_operation = 0; i_wr_enb_ram = 0; i_rd_enb_ram = 0; i_dbg_addr = 0;
    #1 i_reset = 1;
    #1;
    chk("reset_acc", int'(o_acc), 0);
    chk("reset_ovf", int'(o_overflow), 0);
    chk("reset_dbg", int'(o_dbg_data), 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, "reset_hold");
    settle();

    // Immediate sign extension.
    imm_op(1, 0, 11'h3FF); chk("imm_3ff", int'(o_acc), 16'h03FF);
    imm_op(1, 0, 11'h7FF); chk("imm_7ff", int'(o_acc), 16'hFFFF);
    imm_op(1, 0, 11'h400); chk("imm_400", int'(o_acc), 16'hFC00);

    // Store then add from memory.
    imm_op(1, 0, 5);
    drive(0, 3, 0, 0, 0, 1, 0, 3, 3, "store3"); settle();
    imm_op(1, 0, 2);
    drive(0, 2, 0, 0, 1, 0, 1, 3, 3, "add_mem3"); settle();
    chk("add_mem_acc", int'(o_acc), 16'h0007);
    chk("add_mem_dbg", int'(o_dbg_data), 16'h0005);

    // Same-cycle store and load on one address returns the old word.
    imm_op(1, 0, 11'h0AA);
    drive(0, 3, 0, 0, 0, 1, 0, 5, 5, "store5"); settle();
    imm_op(1, 0, 11'h010);
    drive(0, 0, 0, 0, 1, 1, 1, 5, 5, "swap5");
    #1 chk("swap_dbg_pre", int'(o_dbg_data), 16'h00AA);
    settle();
    chk("swap_acc", int'(o_acc), 16'h00AA);
    chk("swap_dbg_post", int'(o_dbg_data), 16'h0010);

    // Disabled read loads zero.
    drive(0, 0, 0, 0, 1, 0, 0, 5, 5, "rd_off"); settle();
    chk("rd_off_acc", int'(o_acc), 0);

    // Subtraction without overflow.
    imm_op(1, 0, 3);
    imm_op(2, 1, 5);
    chk("sub_acc", int'(o_acc), 16'hFFFE);
    chk("sub_ovf", int'(o_overflow), 0);

    // Build 0x7FFF, then overflow on +1, flag sticky.
    imm_op(1, 0, 11'h3FF);
    for (int i = 0; i < 31; i++) imm_op(2, 0, 11'h3FF);
    imm_op(2, 0, 31);
    chk("build_7fff", int'(o_acc), 16'h7FFF);
    chk("no_ovf_yet", int'(o_overflow), 0);
    imm_op(2, 0, 1);
    chk("ovf_add_acc", int'(o_acc), 16'h8000);
    chk("ovf_add_flag", int'(o_overflow), 1);
    imm_op(1, 0, 0);
    chk("ovf_sticky", int'(o_overflow), 1);

    // Build 0x1234, save it, reset mid-cycle, and try to write during reset.
    imm_op(1, 0, 11'h3FF);
    for (int i = 0; i < 3; i++) imm_op(2, 0, 11'h3FF);
    imm_op(2, 0, 11'h238);
    chk("build_1234", int'(o_acc), 16'h1234);
    drive(0, 3, 0, 0, 0, 1, 0, 7, 7, "store7"); settle();
    #1 i_reset = 1;
    m_acc = 0;
    m_ovf = 0;
    #1;
    chk("midreset_acc", int'(o_acc), 0);
    chk("midreset_ovf", int'(o_overflow), 0);
    for (int i = 0; i < 2; i++) drive(1, 1, 1, 0, 1, 1, 0, 7, 7, "wr_in_reset");
    settle();
    chk("wr_suppressed", int'(o_dbg_data), 16'h1234);

    // Build 0x8000 without overflow, then sub 1 overflows.
    imm_op(1, 0, 11'h400);
    for (int i = 0; i < 31; i++) imm_op(2, 1, 11'h3FF);
    imm_op(2, 1, 31);
    chk("build_8000", int'(o_acc), 16'h8000);
    chk("build_8000_ovf", int'(o_overflow), 0);
    imm_op(2, 1, 1);
    chk("ovf_sub_acc", int'(o_acc), 16'h7FFF);
    chk("ovf_sub_flag", int'(o_overflow), 1);

    // Randomized traffic checked by the monitor against the model.
    for (int n = 0; n < 400; n++) begin
      int addr, dbg;
      addr = ($urandom_range(0, 3) != 0) ? $urandom_range(0, 7) : $urandom_range(0, 2047);
      dbg  = ($urandom_range(0, 3) != 0) ? $urandom_range(0, 7) : $urandom_range(0, 2047);
      drive(($urandom_range(0, 63) == 0) ? 1 : 0, $urandom_range(0, 3), $urandom_range(0, 1),
            $urandom_range(0, 1), ($urandom_range(0, 3) != 0) ? 1 : 0, $urandom_range(0, 1),
            ($urandom_range(0, 4) != 0) ? 1 : 0, addr, dbg, "rand");
    end
    settle();
    repeat (2) @(posedge clk);
    #3;
    chk("queue_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
